// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the FP unit: operand layout, constants and accumulator FSM states.
package fp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  localparam int          FP16_BIAS       = 15;
  localparam int          FP16_EXP_MAX    = 30;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] FP16_ZERO       = 16'h0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} accum_state_t;

  // Exponent 31 is read as the largest finite exponent; exponent 0 stays 0 (flush-to-zero).
  function automatic logic [4:0] fp16_exp_eff(input fp16_t x);
    return (x.exp == 5'd31) ? 5'(FP16_EXP_MAX) : x.exp;
  endfunction

  function automatic logic [10:0] fp16_sig(input fp16_t x);
    if (x.exp == 5'd0) return 11'd0;
    if (x.exp == 5'd31) return 11'h7FF;
    return {1'b1, x.man};
  endfunction

  function automatic logic fp16_sign_eff(input fp16_t x);
    return (x.exp == 5'd0) ? 1'b0 : x.sign;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W  = 15,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_accum16.sv
// Multi-cycle FP16 accumulator (IDLE/ALIGN/ADD/NORM/DONE) with flush-to-zero and saturation.
// Define FP_ACCUM16_ROUND_EN for round-to-nearest-even in NORM; otherwise guard bits are truncated.
module fp_accum16
  import fp16_pkg::*;
#(
  parameter int GUARD_BITS    = 3,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_fp,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_fp,
  output logic        out_ovf
);

  localparam int SW = 11 + GUARD_BITS;
  localparam int AW = SW + 1;
  localparam int CW = $clog2(AW + 1);

  accum_state_t  state_q, state_d;
  fp16_t         op_q, op_d, acc_q, acc_d;
  logic          last_q, last_d;
  logic [SW-1:0] sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [4:0]    exp_q, exp_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          sum_sign_q, sum_sign_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   out_fp_q, out_fp_d;

  logic [4:0]    acc_exp, op_exp, exp_diff;
  logic [SW-1:0] acc_sig, op_sig, small_sig;
  logic          acc_big;

  // Operand a always carries the larger exponent; b is shifted down to match it.
  always_comb begin
    acc_exp   = fp16_exp_eff(acc_q);
    op_exp    = fp16_exp_eff(op_q);
    acc_sig   = SW'(fp16_sig(acc_q)) << GUARD_BITS;
    op_sig    = SW'(fp16_sig(op_q)) << GUARD_BITS;
    acc_big   = (acc_exp >= op_exp);
    exp_diff  = acc_big ? (acc_exp - op_exp) : (op_exp - acc_exp);
    small_sig = acc_big ? op_sig : acc_sig;
    if (int'(exp_diff) >= SW) small_sig = '0;
    else small_sig = small_sig >> exp_diff;
  end

  logic [CW-1:0]     lzc, shamt;
  logic [SW-1:0]     norm_sig;
  logic signed [7:0] norm_exp;
  logic [9:0]        res_man;
  logic [15:0]       norm_res;
  logic              norm_ovf;
`ifdef FP_ACCUM16_ROUND_EN
  logic                  sticky_lo, round_up;
  logic [GUARD_BITS-1:0] grd;
  logic [11:0]           rnd_sig;
`else
  logic                  unused_bits;
`endif

  fp_lzc #(.W(AW), .CW(CW)) u_lzc (
    .value(sum_q),
    .count(lzc)
  );

  // The top sum bit is the carry slot, so a normal result needs lzc-1 left shifts.
  always_comb begin
    shamt = lzc - CW'(1);
    if (sum_q[AW-1]) begin
      norm_sig = sum_q[AW-1:1];
      norm_exp = $signed({3'b000, exp_q}) + 8'sd1;
    end else begin
      norm_sig = SW'(sum_q << shamt);
      norm_exp = $signed({3'b000, exp_q}) - $signed(8'(shamt));
    end
`ifdef FP_ACCUM16_ROUND_EN
    sticky_lo = sum_q[AW-1] & sum_q[0];
    grd       = norm_sig[GUARD_BITS-1:0];
    round_up  = grd[GUARD_BITS-1] & ((|(grd << 1)) | sticky_lo | norm_sig[GUARD_BITS]);
    rnd_sig   = 12'(norm_sig >> GUARD_BITS) + 12'(round_up);
    if (rnd_sig[11]) begin
      res_man  = rnd_sig[10:1];
      norm_exp = norm_exp + 8'sd1;
    end else begin
      res_man = rnd_sig[9:0];
    end
`else
    res_man     = norm_sig[SW-2:GUARD_BITS];
    unused_bits = ^{norm_sig[SW-1], norm_sig[GUARD_BITS-1:0]};
`endif
    norm_ovf = 1'b0;
    if (sum_q == '0 || norm_exp < 8'sd1) begin
      norm_res = FP16_ZERO;
    end else if (norm_exp > 8'(FP16_EXP_MAX)) begin
      norm_res = {sum_sign_q, FP16_MAX_FINITE[14:0]};
      norm_ovf = 1'b1;
    end else begin
      norm_res = {sum_sign_q, norm_exp[4:0], res_man};
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_d     = last_q;
    acc_d      = acc_q;
    sig_a_d    = sig_a_q;
    sig_b_d    = sig_b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    exp_d      = exp_q;
    sum_d      = sum_q;
    sum_sign_d = sum_sign_q;
    ovf_d      = ovf_q;
    out_fp_d   = out_fp_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = in_fp;
          last_d  = in_last;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        sig_a_d  = acc_big ? acc_sig : op_sig;
        sig_b_d  = small_sig;
        sign_a_d = acc_big ? fp16_sign_eff(acc_q) : fp16_sign_eff(op_q);
        sign_b_d = acc_big ? fp16_sign_eff(op_q) : fp16_sign_eff(acc_q);
        exp_d    = acc_big ? acc_exp : op_exp;
        state_d  = ADD;
      end
      ADD: begin
        if (sign_a_q == sign_b_q) begin
          sum_d      = {1'b0, sig_a_q} + {1'b0, sig_b_q};
          sum_sign_d = sign_a_q;
        end else if (sig_a_q >= sig_b_q) begin
          sum_d      = {1'b0, sig_a_q} - {1'b0, sig_b_q};
          sum_sign_d = sign_a_q;
        end else begin
          sum_d      = {1'b0, sig_b_q} - {1'b0, sig_a_q};
          sum_sign_d = sign_b_q;
        end
        state_d = NORM;
      end
      NORM: begin
        acc_d = norm_res;
        ovf_d = ovf_q | norm_ovf;
        if (last_q) begin
          out_fp_d = norm_res;
          state_d  = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          state_d = IDLE;
          if (CLEAR_ON_READ) acc_d = FP16_ZERO;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= FP16_ZERO;
      last_q      <= 1'b0;
      acc_q       <= FP16_ZERO;
      sig_a_q     <= '0;
      sig_b_q     <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      sum_sign_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_fp_q    <= FP16_ZERO;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_q       <= exp_d;
      sum_q       <= sum_d;
      sum_sign_q  <= sum_sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      out_fp_q    <= out_fp_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fp_accum16.sv
// Directed self-checking bench for fp_accum16; expected sums are hand-computed FP16 values.
module tb_fp_accum16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_fp;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_fp;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

`ifdef FP_ACCUM16_ROUND_EN
  localparam logic [15:0] EXP_TIE = 16'h6802;
`else
  localparam logic [15:0] EXP_TIE = 16'h6801;
`endif

  fp_accum16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fp    (in_fp),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_fp   (out_fp),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Returns 1 ns after the accepting clock edge.
  task automatic applyStimulus(input logic [15:0] fp, input logic last);
    int waitCycles = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (in_ready !== 1'b1) checkOutput("in_ready_timeout", {15'b0, in_ready}, 16'h0001);
    in_fp    = fp;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts clock edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic waitValid(output int cycles);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic readResult(input string tag, input logic [15:0] expFp, input logic expOvf);
    int cycles;
    waitValid(cycles);
    checkOutput({tag, "_lat"}, 16'(cycles), 16'd4);
    checkOutput({tag, "_fp"}, out_fp, expFp);
    checkOutput({tag, "_ovf"}, {15'b0, out_ovf}, {15'b0, expOvf});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_rdy_vld"}, {14'b0, in_ready, out_valid}, 16'h0002);
  endtask

  initial begin
    int cycles;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fp     = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("rst_out_fp", out_fp, 16'h0000);
    checkOutput("rst_out_ovf", {15'b0, out_ovf}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    readResult("sum3", 16'h4200, 1'b0);

    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'hBC00, 1'b1);
    readResult("cancel", 16'h0000, 1'b0);

    applyStimulus(16'h0001, 1'b1);
    readResult("denorm", 16'h0000, 1'b0);

    applyStimulus(16'h7BFF, 1'b0);
    applyStimulus(16'h7BFF, 1'b1);
    readResult("sat", 16'h7BFF, 1'b1);

    applyStimulus(16'h3C00, 1'b1);
    readResult("after_sat", 16'h3C00, 1'b0);

    applyStimulus(16'h6800, 1'b0);
    applyStimulus(16'h4200, 1'b1);
    readResult("tie", EXP_TIE, 1'b0);

    applyStimulus(16'h6400, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    readResult("small", 16'h6401, 1'b0);

    applyStimulus(16'h4000, 1'b0);
    applyStimulus(16'hBC00, 1'b1);
    readResult("sub", 16'h3C00, 1'b0);

    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'hC000, 1'b1);
    readResult("neg", 16'hBC00, 1'b0);

    applyStimulus(16'h7C00, 1'b1);
    readResult("exp31", 16'h7BFF, 1'b0);

    // Result held under backpressure while an operand is offered and must be ignored.
    applyStimulus(16'h4000, 1'b1);
    waitValid(cycles);
    checkOutput("bp_lat", 16'(cycles), 16'd4);
    @(negedge clk);
    in_valid = 1'b1;
    in_fp    = 16'h3C00;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_fp", out_fp, 16'h4000);
      checkOutput("bp_in_ready", {15'b0, in_ready}, 16'h0000);
      checkOutput("bp_out_valid", {15'b0, out_valid}, 16'h0001);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release", {14'b0, in_ready, out_valid}, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_no_consume", {15'b0, out_valid}, 16'h0000);

    applyStimulus(16'h3C00, 1'b1);
    readResult("post_bp", 16'h3C00, 1'b0);

    // Reset while the operand sits in ADD.
    applyStimulus(16'h4000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("mid_rst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("mid_rst_out_fp", out_fp, 16'h0000);
    checkOutput("mid_rst_out_ovf", {15'b0, out_ovf}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h3C00, 1'b1);
    readResult("rst_resume", 16'h3C00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
